// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - two-cycle byte/half/word data-memory responder for load/store instructions
// Optional misaligned-access trap: DMEM_MISALIGN_TRAP_EN
module dmem_responder #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic          rdQ;
  logic          wrQ;
  logic [2:0]    f3Q;
  logic [AW+1:0] addrQ;
  logic [31:0]   wdataQ;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          isByte;
  logic          isHalf;
  logic [1:0]    lane;
  logic [AW-1:0] wordIdx;
  logic [31:0]   curWord;
  logic [7:0]    ldByte;
  logic [15:0]   ldHalf;
  logic [31:0]   loadVal;
  logic [31:0]   storeWord;
  logic          doStore;

  // Everything below works from the latched request, so input changes during ACCESS are harmless.
  always_comb begin
    isByte = (f3Q[1:0] == 2'b00);
    isHalf = (f3Q[1:0] == 2'b01);
    lane   = addrQ[1:0];
    if (isHalf)
      lane[0] = 1'b0;
    else if (!isByte)
      lane = 2'b00;
    wordIdx = addrQ[AW+1:2];
    curWord = mem[wordIdx];
    ldByte  = curWord[{lane, 3'b000} +: 8];
    ldHalf  = lane[1] ? curWord[31:16] : curWord[15:0];
    if (isByte)
      loadVal = f3Q[2] ? {24'h0, ldByte} : {{24{ldByte[7]}}, ldByte};
    else if (isHalf)
      loadVal = f3Q[2] ? {16'h0, ldHalf} : {{16{ldHalf[15]}}, ldHalf};
    else
      loadVal = curWord;
    storeWord = curWord;
    if (isByte)
      storeWord[{lane, 3'b000} +: 8] = wdataQ[7:0];
    else if (isHalf)
      storeWord[{lane[1], 4'b0000} +: 16] = wdataQ[15:0];
    else
      storeWord = wdataQ;
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic trap;
  assign trap    = isHalf ? addrQ[0] : (!isByte && (addrQ[1:0] != 2'b00));
  assign doStore = rst_n && (state == ACCESS) && wrQ && !trap;
`else
  assign doStore = rst_n && (state == ACCESS) && wrQ;
`endif

  assign stall = rst_n && ((state == IDLE) ? (MemRead | MemWrite) : (state == ACCESS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rdata  <= 32'h0;
      rdQ    <= 1'b0;
      wrQ    <= 1'b0;
      f3Q    <= 3'b000;
      addrQ  <= '0;
      wdataQ <= 32'h0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (MemRead || MemWrite) begin
            rdQ    <= MemRead;
            wrQ    <= MemWrite;
            f3Q    <= funct3;
            addrQ  <= addr[AW+1:0];
            wdataQ <= wdata;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          state <= DONE;
`ifdef DMEM_MISALIGN_TRAP_EN
          misalign <= trap;
          if (rdQ && !wrQ)
            rdata <= trap ? 32'h0 : loadVal;
`else
          if (rdQ && !wrQ)
            rdata <= loadVal;
`endif
        end
        DONE: begin
          // The request still present here belongs to the instruction now completing.
          state <= IDLE;
`ifdef DMEM_MISALIGN_TRAP_EN
          misalign <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (doStore)
      mem[wordIdx] <= storeWord;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V datapath. It services the MemRead/MemWrite requests issued by the main controller for load and store instructions, performs byte/half/word accesses on an internal word-organised memory, and stalls the datapath for a fixed two-cycle access. It is the memory-side counterpart of the controller's MemRead, MemWrite and MemtoReg signals.

## Interface

- DEPTH_WORDS, 64, number of 32-bit memory words; power of two, at least 4.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MemRead  in  1  load request from the controller.
- MemWrite  in  1  store request from the controller.
- funct3  in  3  access size and sign: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data; the low byte or half is used for sub-word stores.
- rdata  out  32  load result, sign- or zero-extended.
- stall  out  1  freeze PC and pipeline registers while high.
- misalign  out  1  misaligned access flag; exists only under the configuration macro.

## Operation

- FSM has three states: IDLE, ACCESS and DONE.
- IDLE:
  - stall = MemRead | MemWrite, combinational.
  - When a request is present, the block latches MemRead, MemWrite, funct3, addr and wdata, then moves to ACCESS.
- ACCESS:
  - stall = 1.
  - A store commits to memory on the rising edge that leaves ACCESS.
  - A load reads the latched word on the same edge and registers the extended result into rdata.
  - Next state is DONE.
- DONE:
  - stall = 0, so the datapath advances on this edge.
  - Next state is IDLE unconditionally. The request still on the inputs during DONE belongs to the completing instruction and is ignored.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Memory is little-endian. Lane selection:
  - Byte accesses use addr[1:0].
  - Half accesses use addr[1].
- Sub-word stores update only the selected byte lanes.
- Sign extension:
  - funct3 000 and 001 sign-extend.
  - funct3 100 and 101 zero-extend.
  - funct3 011, 110 and 111 are treated as word access.
- If MemRead and MemWrite are both high, the access is a store and rdata is unchanged.
- rdata holds its value until the next completed load. Stores never alter rdata.
- Reset values:
  - State is IDLE, rdata = 0, stall = 0, misalign = 0.
  - Memory contents are not reset and are undefined after power-up.
- Reset mid-operation: asserting rst_n low in ACCESS aborts the access. The pending store is not committed and the FSM returns to IDLE.

## Timing

- Cycle T0 (IDLE, request present): stall = 1 and inputs are latched at the end of T0.
- Cycle T1 (ACCESS): stall = 1. The store write and the rdata register update both happen at the end of T1.
- Cycle T2 (DONE): stall = 0 and rdata is valid. The load result is written back at the end of T2.
- Each memory instruction costs exactly 2 stall cycles.
- Back-to-back memory instructions: the next request is seen in IDLE at T3, so its stall rises at T3.
- Non-memory instructions pass with zero stall.
- Input changes during ACCESS have no effect, because the latched copy is used.

## Configuration

- DMEM_MISALIGN_TRAP_EN:
  - Defined:
    - The misalign port exists.
    - An access is misaligned if it is a half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0.
    - On a misaligned access, misalign goes high in DONE for one cycle, the store is suppressed, and a load returns rdata = 0.
    - Timing and stall are unchanged.
  - Not defined:
    - No misalign port.
    - Low address bits below the access size are forced to zero, which aligns the access down.

## Test plan

- Reset, then SW to addr 0x8 with data 0xDEADBEEF, then LW from 0x8 -> stall is high for 2 cycles on each access; rdata = 0xDEADBEEF in DONE.
- SB to 0x9 with data 0x80, then LB from 0x9 and LBU from 0x9 -> LB gives 0xFFFFFF80 and LBU gives 0x00000080. LW from 0x8 gives 0xDEAD80EF.
- SH to 0x2 with data 0x1234ABCD, then LH from 0x2 -> 0xFFFFABCD; LHU from 0x2 -> 0x0000ABCD.
- With DEPTH_WORDS = 64, SW to 0x104 with 0x11111111, then LW from 0x004 -> rdata = 0x11111111 (wrap).
- SW to 0x10 in progress, with rst_n pulsed low in ACCESS -> stall = 0 and state is IDLE immediately. A later LW from 0x10 returns the value held there before the aborted store.
- With DMEM_MISALIGN_TRAP_EN, SW to 0x21 -> misalign is high for one cycle in DONE and memory word 8 is unchanged. Without the macro, the same SW writes word 0x20.
